// File: rtl/spike_train_tx_if.sv
// Command and spike-bus signals of the spike train transmitter.
// master: command source / spike consumer. slave: the transmitter.
interface spike_train_tx_if #(
    parameter int GAP_W = 8,
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       cmd_amp;
    logic [GAP_W-1:0] cmd_gap;
    logic [CNT_W-1:0] cmd_cnt;
    logic             abort;
    logic [7:0]       spike;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, cmd_amp, cmd_gap, cmd_cnt, abort,
        input  cmd_ready, spike, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_amp, cmd_gap, cmd_cnt, abort,
        output cmd_ready, spike, busy, done
    );
endinterface

// File: rtl/spike_train_tx.sv
// Spike train transmitter: turns a {amp, gap, cnt} command into cnt one-cycle
// spikes of value amp, separated by gap zero cycles, on the neuron spike bus.
//
// state | meaning
// IDLE  | ready for a command, bus at zero
// FIRE  | spike cycle, bus = latched amplitude
// GAP   | zero cycles between two spikes of the same train
// DONE0 | zero-length train: done pulse only, bus stays zero
module spike_train_tx #(
    parameter int GAP_W = 8,
    parameter int CNT_W = 8
) (
    input logic              clk,
    input logic              rst,
    spike_train_tx_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FIRE, GAP, DONE0} state_t;

    state_t           state;
    logic [7:0]       amp_q;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_cnt;
    logic [CNT_W-1:0] rem;
    logic [7:0]       spike_q;
    logic             busy_q;
    logic             done_q;
    logic             accept;

    // Ready is combinational so a command can be taken the first IDLE cycle.
    assign bus.cmd_ready = (state == IDLE) && !rst;
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign bus.spike     = spike_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    // Train sequencer; rem counts spikes still to be shown including the current one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            amp_q   <= '0;
            gap_q   <= '0;
            gap_cnt <= '0;
            rem     <= '0;
            spike_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    spike_q <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (accept) begin
                        amp_q <= bus.cmd_amp;
                        gap_q <= bus.cmd_gap;
                        rem   <= bus.cmd_cnt;
                        if (bus.cmd_cnt == '0) begin
                            state  <= DONE0;
                            done_q <= 1'b1;
                        end else begin
                            state   <= FIRE;
                            spike_q <= bus.cmd_amp;
                            busy_q  <= 1'b1;
                            done_q  <= (bus.cmd_cnt == CNT_W'(1));
                        end
                    end
                end
                FIRE: begin
                    if (bus.abort || rem == CNT_W'(1)) begin
                        state   <= IDLE;
                        spike_q <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else begin
                        rem <= rem - CNT_W'(1);
                        if (gap_q != '0) begin
                            state   <= GAP;
                            gap_cnt <= gap_q;
                            spike_q <= '0;
                            done_q  <= 1'b0;
                        end else begin
                            spike_q <= amp_q;
                            done_q  <= (rem == CNT_W'(2));
                        end
                    end
                end
                GAP: begin
                    if (bus.abort) begin
                        state   <= IDLE;
                        spike_q <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else if (gap_cnt == GAP_W'(1)) begin
                        state   <= FIRE;
                        spike_q <= amp_q;
                        done_q  <= (rem == CNT_W'(1));
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                DONE0: begin
                    state   <= IDLE;
                    spike_q <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    spike_q <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spike_train_tx.sv
// Bench for spike_train_tx: directed commands, expected per-cycle bus activity
// queued at acceptance and checked by an independent monitor.
module tb_spike_train_tx;
    typedef struct {
        int         cyc;
        logic [7:0] spike;
        logic       busy;
        logic       done;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    exp_t e;
    int   k, k1, k2;

    spike_train_tx_if #(.GAP_W(8), .CNT_W(8)) bus();

    spike_train_tx #(.GAP_W(8), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle index: cycle n is the period following rising edge n.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle the bus shows activity, pop and compare one expectation.
    always @(negedge clk) begin
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.spike !== 8'd0) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output cyc=%0d: got spike=%0d busy=%b done=%b, required idle bus",
                         cyc, bus.spike, bus.busy, bus.done);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || bus.spike !== e.spike || bus.busy !== e.busy || bus.done !== e.done) begin
                    errors++;
                    $display("FAIL train_cycle: got cyc=%0d spike=%0d busy=%b done=%b, required cyc=%0d spike=%0d busy=%b done=%b",
                             cyc, bus.spike, bus.busy, bus.done, e.cyc, e.spike, e.busy, e.done);
                end
            end
        end
    end

    // Watchdog against any unforeseen hang.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Expected activity of a train accepted in cycle kk, truncated after kk+lim (lim=0: whole train).
    task automatic push_train(input int a, input int g, input int c, input int kk, input int lim);
        exp_t x;
        int   rel;
        if (c == 0) begin
            x.cyc = kk + 1; x.spike = 8'd0; x.busy = 1'b0; x.done = 1'b1;
            q.push_back(x);
            return;
        end
        for (int i = 0; i < c; i++) begin
            rel = 1 + i * (g + 1);
            if (lim == 0 || rel <= lim) begin
                x.cyc = kk + rel; x.spike = a[7:0]; x.busy = 1'b1; x.done = (i == c - 1);
                q.push_back(x);
            end
            if (i < c - 1) begin
                for (int j = 1; j <= g; j++) begin
                    if (lim == 0 || rel + j <= lim) begin
                        x.cyc = kk + rel + j; x.spike = 8'd0; x.busy = 1'b1; x.done = 1'b0;
                        q.push_back(x);
                    end
                end
            end
        end
    endtask

    // Present a command until accepted; returns the handshake cycle, valid drops the cycle after.
    task automatic send(input int a, input int g, input int c, input int lim, input bit abt, output int kk);
        int n = 0;
        bus.cmd_amp   = a[7:0];
        bus.cmd_gap   = g[7:0];
        bus.cmd_cnt   = c[7:0];
        bus.abort     = abt;
        bus.cmd_valid = 1'b1;
        while (bus.cmd_ready !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL send_timeout: got no ready in %0d cycles, required handshake", n);
            kk = -1;
        end else begin
            kk = cyc;
            push_train(a, g, c, kk, lim);
        end
        tick();
        bus.cmd_valid = 1'b0;
        bus.abort     = 1'b0;
    endtask

    task automatic wait_until(input int t);
        int n = 0;
        while (cyc < t && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if (cyc != t) begin
            errors++;
            $display("FAIL wait_cycle: got cyc=%0d, required cyc=%0d", cyc, t);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || bus.cmd_ready !== 1'b1) && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL idle_timeout: got %0d pending expectations, required 0", q.size());
        end
    endtask

    // Directed stimulus.
    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_amp   = '0;
        bus.cmd_gap   = '0;
        bus.cmd_cnt   = '0;
        bus.abort     = 1'b0;
        rst           = 1'b1;
        repeat (3) tick();
        chk("reset_spike", 32'(bus.spike), 0);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_done", 32'(bus.done), 0);
        chk("reset_ready", 32'(bus.cmd_ready), 0);
        rst = 1'b0;
        tick();
        chk("ready_after_reset", 32'(bus.cmd_ready), 1);

        // 1: amp=60 gap=5 cnt=5, ready back at k+26
        send(60, 5, 5, 0, 1'b0, k);
        wait_until(k + 25);
        chk("c1_ready_last_spike", 32'(bus.cmd_ready), 0);
        tick();
        chk("c1_ready_after_done", 32'(bus.cmd_ready), 1);
        wait_idle();

        // 2 + 6: back-to-back, valid held, new fields shown while busy
        send(80, 0, 3, 0, 1'b0, k1);
        send(33, 1, 2, 0, 1'b0, k2);
        chk("c6_second_accept_cycle", 32'(k2), 32'(k1 + 4));
        wait_idle();

        // 3: zero-count train
        send(70, 0, 0, 0, 1'b0, k);
        chk("c3_ready_k1", 32'(bus.cmd_ready), 0);
        tick();
        chk("c3_ready_k2", 32'(bus.cmd_ready), 1);
        wait_idle();

        // 4: abort during a gap, then a normal train
        send(50, 4, 10, 8, 1'b0, k);
        wait_until(k + 8);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("c4_ready_k9", 32'(bus.cmd_ready), 1);
        chk("c4_busy_k9", 32'(bus.busy), 0);
        chk("c4_spike_k9", 32'(bus.spike), 0);
        wait_idle();
        send(21, 2, 3, 0, 1'b0, k);
        wait_idle();

        // 5: reset mid-train with valid held during reset
        send(60, 5, 5, 3, 1'b0, k);
        wait_until(k + 3);
        rst           = 1'b1;
        bus.cmd_amp   = 8'd99;
        bus.cmd_gap   = 8'd0;
        bus.cmd_cnt   = 8'd1;
        bus.cmd_valid = 1'b1;
        tick();
        chk("c5_spike_after_rst", 32'(bus.spike), 0);
        chk("c5_busy_after_rst", 32'(bus.busy), 0);
        chk("c5_ready_in_rst", 32'(bus.cmd_ready), 0);
        tick();
        bus.cmd_valid = 1'b0;
        rst           = 1'b0;
        repeat (4) tick();
        wait_idle();

        // 7: abort in IDLE with a handshake, zero amplitude
        send(0, 2, 2, 0, 1'b1, k);
        wait_idle();

        // 8, 9: maximum gap and maximum count
        send(1, 255, 2, 0, 1'b0, k);
        wait_idle();
        send(255, 0, 255, 0, 1'b0, k);
        wait_idle();

        repeat (3) tick();
        chk("leftover_expectations", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
